// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Purpose : shared types for the bit-serial adder: FSM state encoding.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   // IDLE waits for start, RUN processes one bit per clock, DONE flags the result
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Purpose : gate-level one-bit full-adder cell; the only arithmetic in the
//           serial adder, reused once per clock.
// Ports   : i_a, i_b, i_cin  - operand bits and carry-in
//           o_d              - sum bit
//           o_cout           - carry-out (majority of the three inputs)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_d,
   output logic o_cout
);

   logic w_axb;

   assign w_axb  = i_a ^ i_b;
   assign o_d    = w_axb ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Purpose : bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus a
//           carry flip-flop. Operands load on start; parallel sum, carry-out
//           and signed overflow are presented with a one-cycle done pulse.
// Ports   : i_clk        rising-edge clock
//           i_rst        synchronous active-high reset
//           i_start      load request, honoured only when idle and not busy
//           i_a, i_b     addends, captured on an accepted start
//           i_cin        carry-in, captured on an accepted start
//           o_busy       high from the cycle after start through the done cycle
//           o_sum_bit    serial sum bit, valid with o_sum_valid
//           o_sum_valid  high for each of the WIDTH bit cycles
//           o_done       one-cycle completion pulse
//           o_sum        parallel result, held until the next operation shifts
//           o_cout       final carry-out
//           o_ovf        two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_sum_bit,
   output logic             o_sum_valid,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   // One extra bit so the counter cannot wrap even when WIDTH is a power of two
   localparam int             CW     = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  C_ONE  = CW'(1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic             w_s;
   logic             w_c;

   full_adder u_fa (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_d    (w_s),
      .o_cout (w_c)
   );

   // FSM, datapath registers and all registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         o_busy      <= 1'b0;
         o_sum_bit   <= 1'b0;
         o_sum_valid <= 1'b0;
         o_done      <= 1'b0;
         o_sum       <= '0;
         o_cout      <= 1'b0;
         o_ovf       <= 1'b0;
      end else begin
         o_done      <= 1'b0;
         o_sum_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // o_busy is still high during the done cycle, so a start there is ignored
               if (i_start && !o_busy) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_carry <= i_cin;
                  r_cnt   <= '0;
                  o_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  o_busy  <= 1'b0;
               end
            end
            S_RUN: begin
               o_sum       <= {w_s, o_sum[WIDTH-1:1]};
               r_a         <= {1'b0, r_a[WIDTH-1:1]};
               r_b         <= {1'b0, r_b[WIDTH-1:1]};
               r_carry     <= w_c;
               o_sum_bit   <= w_s;
               o_sum_valid <= 1'b1;
               r_cnt       <= r_cnt + C_ONE;
               if (r_cnt == C_LAST) begin
                  // r_carry here is the carry into the MSB
                  o_cout  <= w_c;
                  o_ovf   <= r_carry ^ w_c;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               o_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           k;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, sum_bit, sum_valid, done, cout, ovf;
   logic [W-1:0] sum;

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   exp_t         exp_q[$];
   logic         bits_q[$];
   logic [W-1:0] last_sum = '0;

   serial_adder #(.WIDTH(W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_a         (a),
      .i_b         (b),
      .i_cin       (cin),
      .o_busy      (busy),
      .o_sum_bit   (sum_bit),
      .o_sum_valid (sum_valid),
      .o_done      (done),
      .o_sum       (sum),
      .o_cout      (cout),
      .o_ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // reference: plain integer addition, overflow from operand/result signs
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t e;
      int unsigned full;
      full   = int'(x) + int'(y) + int'(c);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
      e.k    = 0;
      return e;
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t e;
      wait_idle();
      a = x; b = y; cin = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e   = model(x, y, c);
      e.k = cyc;
      exp_q.push_back(e);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
   endtask

   // monitor: collects the serial stream and checks each done against the queue
   always @(negedge clk) begin
      if (!rst) begin
         if (sum_valid) bits_q.push_back(sum_bit);
         if (!sum_valid && !done) chk("sum_hold", 32'(sum), 32'(last_sum));
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               logic [W-1:0] sv;
               e = exp_q.pop_front();
               sv = '0;
               chk("stream_len", 32'(bits_q.size()), 32'(W));
               for (int i = 0; i < W && i < bits_q.size(); i++) sv[i] = bits_q[i];
               chk("stream", 32'(sv), 32'(e.sum));
               chk("sum", 32'(sum), 32'(e.sum));
               chk("cout", 32'(cout), 32'(e.cout));
               chk("ovf", 32'(ovf), 32'(e.ovf));
               chk("latency", 32'(cyc - e.k), 32'(W + 1));
               chk("busy_in_done", 32'(busy), 32'd1);
               last_sum = e.sum;
            end
            bits_q.delete();
         end
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(sum_valid), 32'd0);
      chk("rst_bit", 32'(sum_bit), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      // directed corner cases, issued back-to-back
      run_op(8'h0F, 8'h01, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'h00, 8'h00, 1'b1);
      run_op(8'h7F, 8'h01, 1'b0);
      run_op(8'h80, 8'h80, 1'b0);

      // start during RUN must be ignored
      run_op(8'h05, 8'h03, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // reset in the middle of RUN aborts without a done pulse
      run_op(8'hFF, 8'hFF, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      bits_q.delete();
      last_sum = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      run_op(8'h10, 8'h10, 1'b0);

      // randomized operations
      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_adder
